exception_ctrl: RTL and testbench
=================================

# exception_ctrl

Parametrised commit-stage exception arbiter, successor to the fixed 8-line exception unit. Prioritises interrupts, TLB, address, instruction and arithmetic exceptions plus ERET. Registers CP0 write data (code, EPC, BadVAddr) and the redirect PC. Holds pipeline flush through a two-state FSM until the fetch side has drained, and selects the vector base at run time from Status.BEV and Status.EXL.

## Interface
Parameters:
- INT_WIDTH, 8, number of interrupt lines (1..16)
- BEV_BASE, 32'hBFC00200, vector base when status_bev=1
- NORMAL_BASE, 32'h80000000, vector base when status_bev=0

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  real instruction present at commit; gates all synchronous causes and ERET
- pc, mm_pc, data_vaddr, epc_in  in  32  commit PC, memory-stage PC, data VA, CP0.EPC
- data_we, in_delayslot  in  1  store flag, commit instr is in a delay slot
- inst_miss, data_miss, inst_invalid, data_invalid, inst_illegal, data_illegal, data_dirty  in  1  MMU/address causes
- syscall, brk, unknown_inst, overflow, eret  in  1  decode/ALU causes
- trap  in  1  trap cause (EXC_TRAP_EN only)
- int_flag  in  INT_WIDTH  pending-and-unmasked interrupt lines
- allow_int, status_exl, status_bev  in  1  Status.IE&!EXL&!ERL, Status.EXL, Status.BEV
- fetch_data_ok, fetch_busy  in  1  fetch response beat, fetch transaction outstanding
- exc_now  out  1  combinational: event accepted this cycle
- flush, wr_exp, clear_exl, badvaddr_we  out  1  registered
- exp_code  out  5  ExcCode
- epc, badvaddr, exception_new_pc  out  32  registered

## Operation
- Event = (allow_int & |int_flag) | (valid_i & any synchronous cause | valid_i & eret). exc_now = event & state==IDLE.
- Priority, highest first: interrupt (0x00), data_dirty&data_we MOD (0x01), inst_miss TLBL (0x02), data_miss TLBL/TLBS (0x02/0x03 by data_we), inst_invalid TLBL, data_invalid TLBL/TLBS, inst_illegal ADEL (0x04), data_illegal ADEL/ADES (0x04/0x05), syscall SYS (0x08), brk BP (0x09), unknown_inst RI (0x0A), overflow OV (0x0C), trap TR (0x0D), eret.
- Base = status_bev ? BEV_BASE : NORMAL_BASE. Offset 0x000 for inst_miss/data_miss when status_exl=0, else 0x180. All other exceptions use 0x180.
- EPC for every exception including interrupt = in_delayslot ? pc-4 : pc (mod 2^32). mm_pc is used only when valid_i=0 for interrupts: mm_pc, or mm_pc-4 if in_delayslot.
- BadVAddr: pc for inst_* causes, data_vaddr for data_* causes. badvaddr_we pulses 1 cycle; badvaddr holds its value otherwise.
- ERET: wr_exp=0, clear_exl pulse 1 cycle, exception_new_pc=epc_in, exp_code unchanged.
- FSM IDLE: on exc_now, register outputs, set flush=1, pulse wr_exp (not for ERET), go HOLD.
- FSM HOLD: all event inputs ignored, flush stays 1. When fetch_data_ok | !fetch_busy is sampled, flush=0 next cycle and state returns to IDLE.

## Timing
- Reset values: flush, wr_exp, clear_exl, badvaddr_we = 0. exp_code=0, epc=badvaddr=0. exception_new_pc=BEV_BASE+0x180. State IDLE.
- Event sampled at edge t drives outputs valid from t+1. wr_exp, badvaddr_we and clear_exl are high exactly cycle t+1.
- Minimum flush width is 1 cycle, when the release condition is true at edge t+1. There is no upper bound while fetch_busy=1 and fetch_data_ok=0.
- An event arriving during HOLD is dropped; the pipeline is flushed, so the upstream block re-presents it.
- Back-to-back: an event in the first IDLE cycle after HOLD is accepted.
- rst in any state returns to IDLE with reset values on the next edge, including during HOLD.
- Interrupt and synchronous cause in the same cycle: the interrupt wins, with EPC from pc.

## Configuration
- EXC_TRAP_EN defined: trap port exists, is gated by valid_i, has priority just below overflow, and produces ExcCode 0x0D.
- EXC_TRAP_EN undefined: no trap port, no TR path, and ExcCode 0x0D is never generated.

## Test plan
- Reset, then idle 5 cycles: flush=0, exception_new_pc=32'hBFC00380, no pulses.
- valid_i=1, syscall=1, pc=32'h80001004, in_delayslot=1, bev=0, fetch_busy=0: next cycle exp_code=0x08, epc=32'h80001000, new_pc=32'h80000180, wr_exp 1 cycle, flush 1 cycle.
- data_miss, data_we=1, exl=0, bev=1, data_vaddr=32'h00400010: exp_code=0x03, new_pc=32'hBFC00200, badvaddr=32'h00400010. Repeat with exl=1: new_pc=32'hBFC00380.
- allow_int=1, int_flag=1, plus overflow in the same cycle: exp_code=0x00. Hold fetch_busy=1 for 4 cycles, then fetch_data_ok: flush high 5 cycles, and a syscall during HOLD produces no wr_exp.
- eret, epc_in=32'h80002000: clear_exl 1 cycle, wr_exp=0, new_pc=32'h80002000. Assert rst during the following HOLD: flush=0 next cycle.
- EXC_TRAP_EN build, trap=1 with overflow=0: exp_code=0x0D. Non-EXC_TRAP_EN build: ExcCode 0x0D never appears.

Source files
------------

// File: rtl/exception_ctrl_if.sv
// Commit-stage exception bus between the pipeline and exception_ctrl.
// The trap line exists only when EXC_TRAP_EN is defined.
interface exception_ctrl_if #(
    parameter int unsigned INT_WIDTH = 8
);
    // Causes and context from commit, MMU, decode and CP0
    logic                 valid_i;
    logic [31:0]          pc;
    logic [31:0]          mm_pc;
    logic [31:0]          data_vaddr;
    logic [31:0]          epc_in;
    logic                 data_we;
    logic                 in_delayslot;
    logic                 inst_miss;
    logic                 data_miss;
    logic                 inst_invalid;
    logic                 data_invalid;
    logic                 inst_illegal;
    logic                 data_illegal;
    logic                 data_dirty;
    logic                 syscall;
    logic                 brk;
    logic                 unknown_inst;
    logic                 overflow;
    logic                 eret;
`ifdef EXC_TRAP_EN
    logic                 trap;
`endif
    logic [INT_WIDTH-1:0] int_flag;
    logic                 allow_int;
    logic                 status_exl;
    logic                 status_bev;
    logic                 fetch_data_ok;
    logic                 fetch_busy;

    // Results towards CP0 and fetch
    logic                 exc_now;
    logic                 flush;
    logic                 wr_exp;
    logic                 clear_exl;
    logic                 badvaddr_we;
    logic [4:0]           exp_code;
    logic [31:0]          epc;
    logic [31:0]          badvaddr;
    logic [31:0]          exception_new_pc;

    modport master (
`ifdef EXC_TRAP_EN
        output trap,
`endif
        output valid_i, pc, mm_pc, data_vaddr, epc_in, data_we, in_delayslot,
               inst_miss, data_miss, inst_invalid, data_invalid, inst_illegal,
               data_illegal, data_dirty, syscall, brk, unknown_inst, overflow,
               eret, int_flag, allow_int, status_exl, status_bev,
               fetch_data_ok, fetch_busy,
        input  exc_now, flush, wr_exp, clear_exl, badvaddr_we, exp_code, epc,
               badvaddr, exception_new_pc
    );

    modport slave (
`ifdef EXC_TRAP_EN
        input  trap,
`endif
        input  valid_i, pc, mm_pc, data_vaddr, epc_in, data_we, in_delayslot,
               inst_miss, data_miss, inst_invalid, data_invalid, inst_illegal,
               data_illegal, data_dirty, syscall, brk, unknown_inst, overflow,
               eret, int_flag, allow_int, status_exl, status_bev,
               fetch_data_ok, fetch_busy,
        output exc_now, flush, wr_exp, clear_exl, badvaddr_we, exp_code, epc,
               badvaddr, exception_new_pc
    );
endinterface

// File: rtl/exception_ctrl.sv
// Commit-stage exception arbiter: prioritises causes, registers CP0 write data
// and redirect PC, and holds flush until fetch drains. EXC_TRAP_EN adds TR.
module exception_ctrl #(
    parameter int unsigned INT_WIDTH   = 8,
    parameter logic [31:0] BEV_BASE    = 32'hBFC00200,
    parameter logic [31:0] NORMAL_BASE = 32'h80000000
) (
    input logic              clk,
    input logic              rst,
    exception_ctrl_if.slave  bus
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned CODE_W = 5;

    localparam logic [XLEN-1:0] OFS_REFILL  = XLEN'(32'h000);
    localparam logic [XLEN-1:0] OFS_GENERAL = XLEN'(32'h180);
    localparam logic [XLEN-1:0] PC_STEP     = XLEN'(32'h4);

    localparam logic [CODE_W-1:0] EXC_INT  = CODE_W'(5'h00);
    localparam logic [CODE_W-1:0] EXC_MOD  = CODE_W'(5'h01);
    localparam logic [CODE_W-1:0] EXC_TLBL = CODE_W'(5'h02);
    localparam logic [CODE_W-1:0] EXC_TLBS = CODE_W'(5'h03);
    localparam logic [CODE_W-1:0] EXC_ADEL = CODE_W'(5'h04);
    localparam logic [CODE_W-1:0] EXC_ADES = CODE_W'(5'h05);
    localparam logic [CODE_W-1:0] EXC_SYS  = CODE_W'(5'h08);
    localparam logic [CODE_W-1:0] EXC_BP   = CODE_W'(5'h09);
    localparam logic [CODE_W-1:0] EXC_RI   = CODE_W'(5'h0A);
    localparam logic [CODE_W-1:0] EXC_OV   = CODE_W'(5'h0C);
`ifdef EXC_TRAP_EN
    localparam logic [CODE_W-1:0] EXC_TR   = CODE_W'(5'h0D);
`endif

    typedef enum logic {IDLE, HOLD} state_e;

    state_e            state_q, state_d;
    logic              flush_q, flush_d;
    logic              wr_exp_q, wr_exp_d;
    logic              clear_exl_q, clear_exl_d;
    logic              badvaddr_we_q, badvaddr_we_d;
    logic [CODE_W-1:0] exp_code_q, exp_code_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [XLEN-1:0]   badvaddr_q, badvaddr_d;
    logic [XLEN-1:0]   new_pc_q, new_pc_d;

    logic [INT_WIDTH-1:0] int_lines;
    logic                 int_req;
    logic                 trap_req;
    logic                 sync_any;
    logic                 event_req;
    logic                 exc_now_c;
    logic                 is_eret;
    logic                 refill;
    logic                 bad_we;
    logic [XLEN-1:0]      bad_addr;
    logic [CODE_W-1:0]    code;
    logic [XLEN-1:0]      epc_src;
    logic [XLEN-1:0]      epc_val;
    logic [XLEN-1:0]      vec_base;
    logic [XLEN-1:0]      target_pc;

    assign int_lines = INT_WIDTH'(bus.int_flag);
    assign int_req   = bus.allow_int & (|int_lines);

`ifdef EXC_TRAP_EN
    assign trap_req = bus.valid_i & bus.trap;
`else
    assign trap_req = 1'b0;
`endif

    // Dirty-page fault needs a store; a dirty flag on a load is not a cause
    assign sync_any = bus.valid_i & ((bus.data_dirty & bus.data_we) |
                      bus.inst_miss | bus.data_miss | bus.inst_invalid |
                      bus.data_invalid | bus.inst_illegal | bus.data_illegal |
                      bus.syscall | bus.brk | bus.unknown_inst | bus.overflow)
                      | trap_req;
    assign event_req = int_req | sync_any | (bus.valid_i & bus.eret);
    assign exc_now_c = event_req & (state_q == IDLE);

    // Priority decode of the winning cause
    always_comb begin
        code     = EXC_INT;
        refill   = 1'b0;
        bad_we   = 1'b0;
        bad_addr = bus.pc;
        is_eret  = 1'b0;
        if (int_req) begin
            code = EXC_INT;
        end else if (bus.valid_i & bus.data_dirty & bus.data_we) begin
            code = EXC_MOD;  bad_we = 1'b1; bad_addr = bus.data_vaddr;
        end else if (bus.valid_i & bus.inst_miss) begin
            code = EXC_TLBL; refill = 1'b1; bad_we = 1'b1;
        end else if (bus.valid_i & bus.data_miss) begin
            code = bus.data_we ? EXC_TLBS : EXC_TLBL;
            refill = 1'b1; bad_we = 1'b1; bad_addr = bus.data_vaddr;
        end else if (bus.valid_i & bus.inst_invalid) begin
            code = EXC_TLBL; bad_we = 1'b1;
        end else if (bus.valid_i & bus.data_invalid) begin
            code = bus.data_we ? EXC_TLBS : EXC_TLBL;
            bad_we = 1'b1; bad_addr = bus.data_vaddr;
        end else if (bus.valid_i & bus.inst_illegal) begin
            code = EXC_ADEL; bad_we = 1'b1;
        end else if (bus.valid_i & bus.data_illegal) begin
            code = bus.data_we ? EXC_ADES : EXC_ADEL;
            bad_we = 1'b1; bad_addr = bus.data_vaddr;
        end else if (bus.valid_i & bus.syscall) begin
            code = EXC_SYS;
        end else if (bus.valid_i & bus.brk) begin
            code = EXC_BP;
        end else if (bus.valid_i & bus.unknown_inst) begin
            code = EXC_RI;
        end else if (bus.valid_i & bus.overflow) begin
            code = EXC_OV;
`ifdef EXC_TRAP_EN
        end else if (trap_req) begin
            code = EXC_TR;
`endif
        end else if (bus.valid_i & bus.eret) begin
            is_eret = 1'b1;
        end
    end

    // Interrupts taken on a bubble restart from the memory-stage PC
    assign epc_src   = (int_req & ~bus.valid_i) ? bus.mm_pc : bus.pc;
    assign epc_val   = bus.in_delayslot ? (epc_src - PC_STEP) : epc_src;
    assign vec_base  = bus.status_bev ? BEV_BASE : NORMAL_BASE;
    assign target_pc = is_eret ? bus.epc_in :
                       vec_base + ((refill & ~bus.status_exl) ? OFS_REFILL : OFS_GENERAL);

    always_comb begin
        state_d       = state_q;
        flush_d       = flush_q;
        wr_exp_d      = 1'b0;
        clear_exl_d   = 1'b0;
        badvaddr_we_d = 1'b0;
        exp_code_d    = exp_code_q;
        epc_d         = epc_q;
        badvaddr_d    = badvaddr_q;
        new_pc_d      = new_pc_q;
        unique case (state_q)
            IDLE: begin
                if (exc_now_c) begin
                    state_d  = HOLD;
                    flush_d  = 1'b1;
                    new_pc_d = target_pc;
                    if (is_eret) begin
                        clear_exl_d = 1'b1;
                    end else begin
                        wr_exp_d      = 1'b1;
                        exp_code_d    = code;
                        epc_d         = epc_val;
                        badvaddr_we_d = bad_we;
                        if (bad_we) badvaddr_d = bad_addr;
                    end
                end
            end
            HOLD: begin
                if (bus.fetch_data_ok | ~bus.fetch_busy) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            flush_q       <= 1'b0;
            wr_exp_q      <= 1'b0;
            clear_exl_q   <= 1'b0;
            badvaddr_we_q <= 1'b0;
            exp_code_q    <= '0;
            epc_q         <= '0;
            badvaddr_q    <= '0;
            new_pc_q      <= BEV_BASE + OFS_GENERAL;
        end else begin
            state_q       <= state_d;
            flush_q       <= flush_d;
            wr_exp_q      <= wr_exp_d;
            clear_exl_q   <= clear_exl_d;
            badvaddr_we_q <= badvaddr_we_d;
            exp_code_q    <= exp_code_d;
            epc_q         <= epc_d;
            badvaddr_q    <= badvaddr_d;
            new_pc_q      <= new_pc_d;
        end
    end

    assign bus.exc_now          = exc_now_c;
    assign bus.flush            = flush_q;
    assign bus.wr_exp           = wr_exp_q;
    assign bus.clear_exl        = clear_exl_q;
    assign bus.badvaddr_we      = badvaddr_we_q;
    assign bus.exp_code         = exp_code_q;
    assign bus.epc              = epc_q;
    assign bus.badvaddr         = badvaddr_q;
    assign bus.exception_new_pc = new_pc_q;
endmodule

// File: tb/tb_exception_ctrl.sv
// Directed self-checking bench for exception_ctrl; covers both EXC_TRAP_EN builds.
module tb_exception_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    exception_ctrl_if #(.INT_WIDTH(8)) bus ();

    exception_ctrl #(
        .INT_WIDTH  (8),
        .BEV_BASE   (32'hBFC00200),
        .NORMAL_BASE(32'h80000000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.valid_i = 1'b0;       bus.pc = '0;            bus.mm_pc = '0;
        bus.data_vaddr = '0;      bus.epc_in = '0;        bus.data_we = 1'b0;
        bus.in_delayslot = 1'b0;  bus.inst_miss = 1'b0;   bus.data_miss = 1'b0;
        bus.inst_invalid = 1'b0;  bus.data_invalid = 1'b0;
        bus.inst_illegal = 1'b0;  bus.data_illegal = 1'b0;
        bus.data_dirty = 1'b0;    bus.syscall = 1'b0;     bus.brk = 1'b0;
        bus.unknown_inst = 1'b0;  bus.overflow = 1'b0;    bus.eret = 1'b0;
`ifdef EXC_TRAP_EN
        bus.trap = 1'b0;
`endif
        bus.int_flag = '0;        bus.allow_int = 1'b0;   bus.status_exl = 1'b0;
        bus.status_bev = 1'b0;    bus.fetch_data_ok = 1'b0;
        bus.fetch_busy = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;

        // Reset state and quiet idle
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_new_pc", bus.exception_new_pc, 32'hBFC00380);
        chk("rst_exp_code", 32'(bus.exp_code), 32'd0);
        chk("rst_epc", bus.epc, 32'd0);
        chk("rst_badvaddr", bus.badvaddr, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_flush", 32'(bus.flush), 32'd0);
            chk("idle_pulses", {29'd0, bus.wr_exp, bus.clear_exl, bus.badvaddr_we}, 32'd0);
            chk("idle_new_pc", bus.exception_new_pc, 32'hBFC00380);
        end

        // Syscall in a delay slot, fetch idle
        bus.valid_i = 1'b1; bus.syscall = 1'b1; bus.pc = 32'h80001004;
        bus.in_delayslot = 1'b1;
        #1;
        chk("sys_exc_now", 32'(bus.exc_now), 32'd1);
        tick();
        clear_inputs();
        chk("sys_code", 32'(bus.exp_code), 32'h08);
        chk("sys_epc", bus.epc, 32'h80001000);
        chk("sys_new_pc", bus.exception_new_pc, 32'h80000180);
        chk("sys_wr_exp", 32'(bus.wr_exp), 32'd1);
        chk("sys_flush", 32'(bus.flush), 32'd1);
        chk("sys_bad_we", 32'(bus.badvaddr_we), 32'd0);
        tick();
        chk("sys_wr_exp_off", 32'(bus.wr_exp), 32'd0);
        chk("sys_flush_off", 32'(bus.flush), 32'd0);

        // Data TLB refill on a store, EXL clear then set
        bus.valid_i = 1'b1; bus.data_miss = 1'b1; bus.data_we = 1'b1;
        bus.status_bev = 1'b1; bus.data_vaddr = 32'h00400010; bus.pc = 32'h80001100;
        tick();
        clear_inputs();
        chk("dmiss_code", 32'(bus.exp_code), 32'h03);
        chk("dmiss_new_pc", bus.exception_new_pc, 32'hBFC00200);
        chk("dmiss_badvaddr", bus.badvaddr, 32'h00400010);
        chk("dmiss_bad_we", 32'(bus.badvaddr_we), 32'd1);
        tick();
        chk("dmiss_bad_we_off", 32'(bus.badvaddr_we), 32'd0);
        bus.valid_i = 1'b1; bus.data_miss = 1'b1; bus.data_we = 1'b1;
        bus.status_bev = 1'b1; bus.status_exl = 1'b1; bus.data_vaddr = 32'h00400010;
        tick();
        clear_inputs();
        chk("dmiss_exl_code", 32'(bus.exp_code), 32'h03);
        chk("dmiss_exl_new_pc", bus.exception_new_pc, 32'hBFC00380);
        tick();
        tick();
        chk("badvaddr_hold", bus.badvaddr, 32'h00400010);

        // Interrupt beats overflow; flush held while fetch drains
        bus.allow_int = 1'b1; bus.int_flag = 8'h01; bus.valid_i = 1'b1;
        bus.overflow = 1'b1; bus.pc = 32'h80003000; bus.fetch_busy = 1'b1;
        tick();
        clear_inputs();
        bus.fetch_busy = 1'b1;
        chk("int_code", 32'(bus.exp_code), 32'h00);
        chk("int_epc", bus.epc, 32'h80003000);
        chk("int_new_pc", bus.exception_new_pc, 32'h80000180);
        chk("int_wr_exp", 32'(bus.wr_exp), 32'd1);
        chk("int_flush", 32'(bus.flush), 32'd1);
        bus.valid_i = 1'b1; bus.syscall = 1'b1; bus.pc = 32'h80003100;
        #1;
        chk("hold_exc_now", 32'(bus.exc_now), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_flush", 32'(bus.flush), 32'd1);
            chk("hold_wr_exp", 32'(bus.wr_exp), 32'd0);
        end
        bus.valid_i = 1'b0; bus.syscall = 1'b0; bus.fetch_data_ok = 1'b1;
        tick();
        clear_inputs();
        chk("hold_release", 32'(bus.flush), 32'd0);
        chk("hold_code_kept", 32'(bus.exp_code), 32'h00);

        // Back-to-back: interrupt on a bubble uses mm_pc in a delay slot
        bus.allow_int = 1'b1; bus.int_flag = 8'h10; bus.mm_pc = 32'h80004008;
        bus.in_delayslot = 1'b1; bus.pc = 32'h12345678;
        #1;
        chk("b2b_exc_now", 32'(bus.exc_now), 32'd1);
        tick();
        clear_inputs();
        chk("mmint_epc", bus.epc, 32'h80004004);
        chk("mmint_bad_we", 32'(bus.badvaddr_we), 32'd0);
        tick();

        // Load address error outranks syscall
        bus.valid_i = 1'b1; bus.data_illegal = 1'b1; bus.syscall = 1'b1;
        bus.data_vaddr = 32'h00000003; bus.pc = 32'h80006000;
        tick();
        clear_inputs();
        chk("adel_code", 32'(bus.exp_code), 32'h04);
        chk("adel_badvaddr", bus.badvaddr, 32'h00000003);
        chk("adel_new_pc", bus.exception_new_pc, 32'h80000180);
        tick();

        // ERET, then reset during its HOLD
        bus.valid_i = 1'b1; bus.eret = 1'b1; bus.epc_in = 32'h80002000;
        bus.fetch_busy = 1'b1;
        tick();
        clear_inputs();
        bus.fetch_busy = 1'b1;
        chk("eret_clear_exl", 32'(bus.clear_exl), 32'd1);
        chk("eret_wr_exp", 32'(bus.wr_exp), 32'd0);
        chk("eret_new_pc", bus.exception_new_pc, 32'h80002000);
        chk("eret_code_kept", 32'(bus.exp_code), 32'h04);
        chk("eret_flush", 32'(bus.flush), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("hold_rst_flush", 32'(bus.flush), 32'd0);
        chk("hold_rst_clear_exl", 32'(bus.clear_exl), 32'd0);
        chk("hold_rst_new_pc", bus.exception_new_pc, 32'hBFC00380);
        bus.valid_i = 1'b1; bus.syscall = 1'b1; bus.pc = 32'h80005000;
        #1;
        chk("post_rst_exc_now", 32'(bus.exc_now), 32'd1);
        tick();
        clear_inputs();
        chk("post_rst_code", 32'(bus.exp_code), 32'h08);
        chk("post_rst_epc", bus.epc, 32'h80005000);
        tick();

`ifdef EXC_TRAP_EN
        bus.valid_i = 1'b1; bus.trap = 1'b1; bus.pc = 32'h80007000;
        tick();
        clear_inputs();
        chk("trap_code", 32'(bus.exp_code), 32'h0D);
`else
        bus.valid_i = 1'b1; bus.overflow = 1'b1; bus.pc = 32'h80007000;
        tick();
        clear_inputs();
        chk("ov_code", 32'(bus.exp_code), 32'h0C);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
